// File: rtl/axi_burst_bridge.sv
// Cache-to-AXI3 bridge: arbitrates icache/dcache refills onto one AR/R pair and
// drives dcache line/single writebacks as AW/W/B bursts, with a read-after-write line hazard.
module axi_burst_bridge #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  // AR channel
  output logic [ID_W-1:0]              arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [1:0]                   arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic                         arvalid,
  input  logic                         arready,
  // R channel
  input  logic [ID_W-1:0]              rid,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready,
  // AW channel
  output logic [ID_W-1:0]              awid,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic [1:0]                   awlock,
  output logic [3:0]                   awcache,
  output logic [2:0]                   awprot,
  output logic                         awvalid,
  input  logic                         awready,
  // W channel
  output logic [ID_W-1:0]              wid,
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W/8-1:0]          wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  // B channel
  input  logic [ID_W-1:0]              bid,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready,
  // icache refill port
  input  logic                         icache_rd_req,
  input  logic [2:0]                   icache_rd_type,
  input  logic [31:0]                  icache_rd_addr,
  output logic                         icache_rd_rdy,
  output logic                         icache_ret_valid,
  output logic                         icache_ret_last,
  output logic [DATA_W-1:0]            icache_ret_data,
  // dcache refill port
  input  logic                         dcache_rd_req,
  input  logic [2:0]                   dcache_rd_type,
  input  logic [31:0]                  dcache_rd_addr,
  output logic                         dcache_rd_rdy,
  output logic                         dcache_ret_valid,
  output logic                         dcache_ret_last,
  output logic [DATA_W-1:0]            dcache_ret_data,
  // dcache writeback port
  input  logic                         dcache_wr_req,
  input  logic [2:0]                   dcache_wr_type,
  input  logic [31:0]                  dcache_wr_addr,
  input  logic [DATA_W/8-1:0]          dcache_wr_wstrb,
  input  logic [LINE_WORDS*DATA_W-1:0] dcache_wr_data,
  output logic                         dcache_wr_rdy,
  output logic                         bus_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(LINE_WORDS * DATA_W / 8);
  localparam int CNT_W  = $clog2(LINE_WORDS);

  localparam logic [7:0]      LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [2:0]      LINE_SZ   = 3'($clog2(DATA_W / 8));
  localparam logic [2:0]      TYPE_LINE = 3'b100;
  localparam logic [ID_W-1:0] WR_ID     = {{(ID_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_XFER = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  function automatic logic [7:0] burst_len(input logic [2:0] typ);
    return (typ == TYPE_LINE) ? LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] burst_size(input logic [2:0] typ);
    return (typ == TYPE_LINE) ? LINE_SZ : {1'b0, typ[1:0]};
  endfunction

  logic [1:0]        r_rstate;
  logic              r_rclient;
  logic [31:0]       r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;

  logic [1:0]        r_wstate;
  logic [31:0]       r_awaddr;
  logic [7:0]        r_awlen;
  logic [2:0]        r_awsize;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_wword [LINE_WORDS];
  logic [7:0]        r_wcnt;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_bus_err;

  logic              w_wr_busy;
  logic              w_wr_accept;
  logic              w_haz_d;
  logic              w_haz_i;
  logic              w_grant_d;
  logic              w_grant_i;
  logic [31:0]       w_sel_addr;
  logic [2:0]        w_sel_type;
  logic              w_rbeat;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_w_last;
  logic              w_aw_fin;
  logic              w_w_fin;
  logic              w_unused;

  assign w_unused = ^{rid, bid};

  // Hazard: a read must not overtake a writeback of the same line, pending or accepted now.
  assign w_wr_busy   = (r_wstate != W_IDLE);
  assign w_wr_accept = dcache_wr_req & (r_wstate == W_IDLE);
  assign w_haz_d = (w_wr_busy   & (dcache_rd_addr[31:OFF_W] == r_awaddr[31:OFF_W])) |
                   (w_wr_accept & (dcache_rd_addr[31:OFF_W] == dcache_wr_addr[31:OFF_W]));
  assign w_haz_i = (w_wr_busy   & (icache_rd_addr[31:OFF_W] == r_awaddr[31:OFF_W])) |
                   (w_wr_accept & (icache_rd_addr[31:OFF_W] == dcache_wr_addr[31:OFF_W]));

  assign w_grant_d = (r_rstate == R_IDLE) & dcache_rd_req & ~w_haz_d;
  assign w_grant_i = (r_rstate == R_IDLE) & icache_rd_req & ~w_haz_i & ~w_grant_d;
  assign w_sel_addr = w_grant_d ? dcache_rd_addr : icache_rd_addr;
  assign w_sel_type = w_grant_d ? dcache_rd_type : icache_rd_type;

  assign dcache_rd_rdy = w_grant_d;
  assign icache_rd_rdy = w_grant_i;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_rclient <= 1'b0;
      r_araddr  <= 32'd0;
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_grant_d | w_grant_i) begin
            r_rclient <= w_grant_d;
            r_araddr  <= w_sel_addr;
            r_arlen   <= burst_len(w_sel_type);
            r_arsize  <= burst_size(w_sel_type);
            r_rstate  <= R_AR;
          end
        end
        R_AR:    if (arready) r_rstate <= R_DATA;
        R_DATA:  if (rvalid & rlast) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign arid    = {{(ID_W-1){1'b0}}, r_rclient};
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = (r_rstate == R_AR);
  assign rready  = (r_rstate == R_DATA);

  // Beats go straight through to the owning cache with no buffering.
  assign w_rbeat          = rready & rvalid;
  assign icache_ret_valid = w_rbeat & ~r_rclient;
  assign dcache_ret_valid = w_rbeat & r_rclient;
  assign icache_ret_last  = icache_ret_valid & rlast;
  assign dcache_ret_last  = dcache_ret_valid & rlast;
  assign icache_ret_data  = rdata;
  assign dcache_ret_data  = rdata;

  assign w_aw_hs  = awvalid & awready;
  assign w_w_hs   = wvalid & wready;
  assign w_w_last = (r_wcnt == r_awlen);
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | (w_w_hs & w_w_last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= 32'd0;
      r_awlen   <= 8'd0;
      r_awsize  <= 3'd0;
      r_wstrb   <= '0;
      r_wcnt    <= 8'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) r_wword[i] <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (dcache_wr_req) begin
            r_awaddr  <= dcache_wr_addr;
            r_awlen   <= burst_len(dcache_wr_type);
            r_awsize  <= burst_size(dcache_wr_type);
            r_wstrb   <= (dcache_wr_type == TYPE_LINE) ? {STRB_W{1'b1}} : dcache_wr_wstrb;
            r_wcnt    <= 8'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++)
              r_wword[i] <= dcache_wr_data[i*DATA_W +: DATA_W];
            r_wstate  <= W_XFER;
          end
        end
        W_XFER: begin
          // AW and W complete independently; the response is awaited only once both are done.
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) begin
            r_wcnt <= r_wcnt + 8'd1;
            if (w_w_last) r_w_done <= 1'b1;
          end
          if (w_aw_fin & w_w_fin) r_wstate <= W_RESP;
        end
        W_RESP:  if (bvalid) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign dcache_wr_rdy = (r_wstate == W_IDLE);
  assign awid    = WR_ID;
  assign awaddr  = r_awaddr;
  assign awlen   = r_awlen;
  assign awsize  = r_awsize;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = (r_wstate == W_XFER) & ~r_aw_done;
  assign wvalid  = (r_wstate == W_XFER) & ~r_w_done;
  assign wid     = WR_ID;
  assign wdata   = r_wword[r_wcnt[CNT_W-1:0]];
  assign wstrb   = r_wstrb;
  assign wlast   = wvalid & w_w_last;
  assign bready  = (r_wstate == W_RESP);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bus_err <= 1'b0;
    end else if ((w_rbeat & (rresp != 2'b00)) | (bready & bvalid & (bresp != 2'b00))) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_axi_burst_bridge.sv
// Scenario bench for axi_burst_bridge: tasks drive cache requests and AXI responses,
// expected return/write beats queue up and are checked when the bridge emits them.
module tb_axi_burst_bridge;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int ID_W       = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ID_W-1:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [DATA_W/8-1:0] wstrb, dcache_wr_wstrb;
  logic icache_rd_req, icache_rd_rdy, icache_ret_valid, icache_ret_last;
  logic [2:0] icache_rd_type, dcache_rd_type, dcache_wr_type;
  logic [31:0] icache_rd_addr, dcache_rd_addr, dcache_wr_addr;
  logic [DATA_W-1:0] icache_ret_data, dcache_ret_data;
  logic dcache_rd_req, dcache_rd_rdy, dcache_ret_valid, dcache_ret_last;
  logic dcache_wr_req, dcache_wr_rdy, bus_err;
  logic [LINE_WORDS*DATA_W-1:0] dcache_wr_data;

  axi_burst_bridge #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type),
    .icache_rd_addr(icache_rd_addr), .icache_rd_rdy(icache_rd_rdy),
    .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
    .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type),
    .dcache_rd_addr(dcache_rd_addr), .dcache_rd_rdy(dcache_rd_rdy),
    .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
    .dcache_ret_data(dcache_ret_data),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_type(dcache_wr_type),
    .dcache_wr_addr(dcache_wr_addr), .dcache_wr_wstrb(dcache_wr_wstrb),
    .dcache_wr_data(dcache_wr_data), .dcache_wr_rdy(dcache_wr_rdy), .bus_err(bus_err)
  );

  typedef struct {logic [31:0] data; logic last;} rexp_t;
  typedef struct {logic [31:0] data; logic [3:0] strb; logic last;} wexp_t;
  rexp_t exp_iq[$];
  rexp_t exp_dq[$];
  wexp_t exp_wq[$];
  rexp_t mon_ie, mon_de;
  wexp_t mon_we;

  int errors = 0;
  int checks = 0;

  // Scoreboard: every forwarded read beat and every W handshake must match the queued expectation.
  always @(negedge aclk) begin
    if (icache_ret_valid) begin
      checks++;
      if (exp_iq.size() == 0) begin
        errors++;
        $display("FAIL icache_ret_unexpected: got data=%h last=%b, none expected", icache_ret_data, icache_ret_last);
      end else begin
        mon_ie = exp_iq.pop_front();
        if (icache_ret_data !== mon_ie.data || icache_ret_last !== mon_ie.last) begin
          errors++;
          $display("FAIL icache_ret_beat: got data=%h last=%b, want data=%h last=%b",
                   icache_ret_data, icache_ret_last, mon_ie.data, mon_ie.last);
        end
      end
    end
    if (dcache_ret_valid) begin
      checks++;
      if (exp_dq.size() == 0) begin
        errors++;
        $display("FAIL dcache_ret_unexpected: got data=%h last=%b, none expected", dcache_ret_data, dcache_ret_last);
      end else begin
        mon_de = exp_dq.pop_front();
        if (dcache_ret_data !== mon_de.data || dcache_ret_last !== mon_de.last) begin
          errors++;
          $display("FAIL dcache_ret_beat: got data=%h last=%b, want data=%h last=%b",
                   dcache_ret_data, dcache_ret_last, mon_de.data, mon_de.last);
        end
      end
    end
    if (wvalid && wready) begin
      checks++;
      if (exp_wq.size() == 0) begin
        errors++;
        $display("FAIL w_unexpected: got wdata=%h wlast=%b, none expected", wdata, wlast);
      end else begin
        mon_we = exp_wq.pop_front();
        if (wdata !== mon_we.data || wstrb !== mon_we.strb || wlast !== mon_we.last || wid !== 4'd1) begin
          errors++;
          $display("FAIL w_beat: got wdata=%h wstrb=%b wlast=%b wid=%0d, want wdata=%h wstrb=%b wlast=%b wid=1",
                   wdata, wstrb, wlast, wid, mon_we.data, mon_we.strb, mon_we.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic ar_accept(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      arready = 1'b1;
      step();
      arready = 1'b0;
    end
  endtask

  task automatic r_beats(input logic client, input logic [31:0] base, input int n, input logic [1:0] resp);
    for (int i = 0; i < n; i++) begin
      if (client) exp_dq.push_back('{data: base + 32'(i), last: (i == n - 1)});
      else        exp_iq.push_back('{data: base + 32'(i), last: (i == n - 1)});
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rlast  = (i == n - 1);
      rresp  = resp;
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic wait_bready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic push_line_w(input logic [31:0] w0);
    for (int i = 0; i < LINE_WORDS; i++)
      exp_wq.push_back('{data: w0 + 32'(i), strb: 4'hF, last: (i == LINE_WORDS - 1)});
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, icache_ret_valid, dcache_ret_valid,
         icache_ret_last, dcache_ret_last, bus_err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0", {arvalid, awvalid, wvalid, rready, bready,
               icache_ret_valid, dcache_ret_valid, icache_ret_last, dcache_ret_last, bus_err});
    end
    checks++;
    if (araddr !== 32'd0 || awaddr !== 32'd0 || arlen !== 8'd0 || awlen !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: got araddr=%h awaddr=%h arlen=%0d awlen=%0d, want all 0", araddr, awaddr, arlen, awlen);
    end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_icache_line();
    logic ok;
    icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h1C00_0000;
    #1;
    checks++;
    if (icache_rd_rdy !== 1'b1) begin errors++; $display("FAIL icache_rdy: got %b want 1", icache_rd_rdy); end
    step();
    icache_rd_req = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1C00_0000 || arlen !== 8'd3 || arsize !== 3'd2 ||
        arid !== 4'd0 || arburst !== 2'b01) begin
      errors++;
      $display("FAIL icache_ar: got v=%b addr=%h len=%0d size=%0d id=%0d burst=%b, want 1 1c000000 3 2 0 01",
               arvalid, araddr, arlen, arsize, arid, arburst);
    end
    ar_accept(ok);
    checks++;
    if (!ok || rready !== 1'b1) begin errors++; $display("FAIL icache_ar_hs: got ok=%b rready=%b want 1 1", ok, rready); end
    r_beats(1'b0, 32'hA0, 4, 2'b00);
    checks++;
    if (exp_iq.size() != 0 || rready !== 1'b0) begin
      errors++; $display("FAIL icache_done: got pending=%0d rready=%b want 0 0", exp_iq.size(), rready);
    end
  endtask

  task automatic test_arbitration();
    logic ok;
    icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h0000_0300;
    dcache_rd_req = 1'b1; dcache_rd_type = 3'b100; dcache_rd_addr = 32'h0000_0400;
    #1;
    checks++;
    if (dcache_rd_rdy !== 1'b1 || icache_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL arb_grant: got d_rdy=%b i_rdy=%b want 1 0", dcache_rd_rdy, icache_rd_rdy);
    end
    step();
    dcache_rd_req = 1'b0;
    checks++;
    if (arid !== 4'd1 || araddr !== 32'h400 || icache_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL arb_dcache_ar: got id=%0d addr=%h i_rdy=%b want 1 400 0", arid, araddr, icache_rd_rdy);
    end
    ar_accept(ok);
    r_beats(1'b1, 32'hD0, 4, 2'b00);
    checks++;
    if (!ok || icache_rd_rdy !== 1'b1) begin
      errors++; $display("FAIL arb_icache_after: got ok=%b i_rdy=%b want 1 1", ok, icache_rd_rdy);
    end
    step();
    icache_rd_req = 1'b0;
    checks++;
    if (arid !== 4'd0 || araddr !== 32'h300) begin
      errors++; $display("FAIL arb_icache_ar: got id=%0d addr=%h want 0 300", arid, araddr);
    end
    ar_accept(ok);
    r_beats(1'b0, 32'hB0, 4, 2'b00);
    checks++;
    if (!ok || exp_iq.size() != 0 || exp_dq.size() != 0) begin
      errors++; $display("FAIL arb_done: got ok=%b pending=%0d/%0d want 1 0/0", ok, exp_iq.size(), exp_dq.size());
    end
  endtask

  task automatic test_write_line();
    logic ok;
    push_line_w(32'h10);
    wready = 1'b1; awready = 1'b0;
    dcache_wr_req = 1'b1; dcache_wr_type = 3'b100; dcache_wr_addr = 32'h80;
    dcache_wr_data = {32'h13, 32'h12, 32'h11, 32'h10};
    #1;
    checks++;
    if (dcache_wr_rdy !== 1'b1) begin errors++; $display("FAIL wr_rdy: got %b want 1", dcache_wr_rdy); end
    step();
    dcache_wr_req = 1'b0;
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h80 || awlen !== 8'd3 || awsize !== 3'd2 ||
        awid !== 4'd1 || awburst !== 2'b01 || dcache_wr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wr_aw: got v=%b addr=%h len=%0d size=%0d id=%0d burst=%b rdy=%b, want 1 80 3 2 1 01 0",
               awvalid, awaddr, awlen, awsize, awid, awburst, dcache_wr_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (awvalid !== 1'b1 || bready !== 1'b0) begin
        errors++; $display("FAIL wr_aw_hold: cycle %0d got awvalid=%b bready=%b want 1 0", i, awvalid, bready);
      end
    end
    checks++;
    if (wvalid !== 1'b0 || exp_wq.size() != 0) begin
      errors++; $display("FAIL wr_w_first: got wvalid=%b pending=%0d want 0 0", wvalid, exp_wq.size());
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    checks++;
    if (bready !== 1'b1 || awvalid !== 1'b0) begin
      errors++; $display("FAIL wr_resp: got bready=%b awvalid=%b want 1 0", bready, awvalid);
    end
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    ok = (bready === 1'b0) && (dcache_wr_rdy === 1'b1);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_idle: got bready=%b wr_rdy=%b want 0 1", bready, dcache_wr_rdy); end
  endtask

  task automatic test_hazard();
    logic ok;
    wready = 1'b0; awready = 1'b0;
    dcache_wr_req = 1'b1; dcache_wr_type = 3'b100; dcache_wr_addr = 32'h100;
    dcache_wr_data = {32'h23, 32'h22, 32'h21, 32'h20};
    dcache_rd_req = 1'b1; dcache_rd_type = 3'b100; dcache_rd_addr = 32'h108;
    #1;
    checks++;
    if (dcache_wr_rdy !== 1'b1 || dcache_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL haz_same_cycle: got wr_rdy=%b rd_rdy=%b want 1 0", dcache_wr_rdy, dcache_rd_rdy);
    end
    step();
    dcache_wr_req = 1'b0;
    icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h200;
    #1;
    checks++;
    if (dcache_rd_rdy !== 1'b0 || icache_rd_rdy !== 1'b1) begin
      errors++; $display("FAIL haz_other_line: got d_rdy=%b i_rdy=%b want 0 1", dcache_rd_rdy, icache_rd_rdy);
    end
    step();
    icache_rd_req = 1'b0;
    checks++;
    if (araddr !== 32'h200 || arid !== 4'd0) begin
      errors++; $display("FAIL haz_ar: got addr=%h id=%0d want 200 0", araddr, arid);
    end
    ar_accept(ok);
    r_beats(1'b0, 32'hC0, 4, 2'b00);
    checks++;
    if (!ok || dcache_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL haz_still_blocked: got ok=%b d_rdy=%b want 1 0", ok, dcache_rd_rdy);
    end
    push_line_w(32'h20);
    awready = 1'b1; wready = 1'b1;
    wait_bready(ok);
    checks++;
    if (!ok || dcache_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL haz_in_resp: got bready_seen=%b d_rdy=%b want 1 0", ok, dcache_rd_rdy);
    end
    bvalid = 1'b1; bresp = 2'b00;
    #1;
    checks++;
    if (dcache_rd_rdy !== 1'b0) begin errors++; $display("FAIL haz_b_cycle: got d_rdy=%b want 0", dcache_rd_rdy); end
    step();
    bvalid = 1'b0; awready = 1'b0;
    checks++;
    if (dcache_rd_rdy !== 1'b1) begin errors++; $display("FAIL haz_clear: got d_rdy=%b want 1", dcache_rd_rdy); end
    step();
    dcache_rd_req = 1'b0;
    checks++;
    if (arid !== 4'd1 || araddr !== 32'h108) begin
      errors++; $display("FAIL haz_dcache_ar: got id=%0d addr=%h want 1 108", arid, araddr);
    end
    ar_accept(ok);
    r_beats(1'b1, 32'hE0, 4, 2'b00);
    checks++;
    if (!ok || exp_dq.size() != 0 || exp_wq.size() != 0) begin
      errors++; $display("FAIL haz_done: got ok=%b pending r=%0d w=%0d want 1 0 0", ok, exp_dq.size(), exp_wq.size());
    end
  endtask

  task automatic test_single_write(input logic [1:0] resp);
    logic ok;
    exp_wq.push_back('{data: 32'h55AA_1234, strb: 4'b0011, last: 1'b1});
    awready = 1'b1; wready = 1'b1;
    dcache_wr_req = 1'b1; dcache_wr_type = 3'b010; dcache_wr_addr = 32'h40;
    dcache_wr_wstrb = 4'b0011;
    dcache_wr_data = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'h55AA_1234};
    step();
    dcache_wr_req = 1'b0;
    checks++;
    if (awlen !== 8'd0 || awsize !== 3'd2 || awaddr !== 32'h40 || wvalid !== 1'b1 ||
        wlast !== 1'b1 || wstrb !== 4'b0011) begin
      errors++;
      $display("FAIL single_w: got len=%0d size=%0d addr=%h wvalid=%b wlast=%b wstrb=%b, want 0 2 40 1 1 0011",
               awlen, awsize, awaddr, wvalid, wlast, wstrb);
    end
    wait_bready(ok);
    bvalid = 1'b1; bresp = resp;
    step();
    bvalid = 1'b0; bresp = 2'b00; awready = 1'b0;
    checks++;
    if (!ok || exp_wq.size() != 0 || dcache_wr_rdy !== 1'b1) begin
      errors++; $display("FAIL single_done: got ok=%b pending=%0d wr_rdy=%b want 1 0 1", ok, exp_wq.size(), dcache_wr_rdy);
    end
  endtask

  task automatic test_bus_err_and_reset();
    logic ok;
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clean: got bus_err=%b want 0", bus_err); end
    test_single_write(2'b10);
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL err_set: got bus_err=%b want 1", bus_err); end
    repeat (3) step();
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got bus_err=%b want 1", bus_err); end
    icache_rd_req = 1'b1; icache_rd_type = 3'b100; icache_rd_addr = 32'h2000;
    step();
    icache_rd_req = 1'b0;
    ar_accept(ok);
    checks++;
    if (!ok || rready !== 1'b1) begin errors++; $display("FAIL rst_setup: got ok=%b rready=%b want 1 1", ok, rready); end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (rready !== 1'b0 || arvalid !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rst_async: got rready=%b arvalid=%b bus_err=%b want 0 0 0", rready, arvalid, bus_err);
    end
    step();
    aresetn = 1'b1;
    step();
    icache_rd_req = 1'b1; icache_rd_type = 3'b001; icache_rd_addr = 32'h1004;
    #1;
    checks++;
    if (icache_rd_rdy !== 1'b1) begin errors++; $display("FAIL rst_recover_rdy: got %b want 1", icache_rd_rdy); end
    step();
    icache_rd_req = 1'b0;
    checks++;
    if (arlen !== 8'd0 || arsize !== 3'd1 || araddr !== 32'h1004) begin
      errors++; $display("FAIL single_ar: got len=%0d size=%0d addr=%h want 0 1 1004", arlen, arsize, araddr);
    end
    ar_accept(ok);
    r_beats(1'b0, 32'h77, 1, 2'b00);
    checks++;
    if (!ok || exp_iq.size() != 0) begin
      errors++; $display("FAIL single_r_done: got ok=%b pending=%0d want 1 0", ok, exp_iq.size());
    end
  endtask

  initial begin
    arready = 0; rid = '0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    icache_rd_req = 0; icache_rd_type = 0; icache_rd_addr = 0;
    dcache_rd_req = 0; dcache_rd_type = 0; dcache_rd_addr = 0;
    dcache_wr_req = 0; dcache_wr_type = 0; dcache_wr_addr = 0;
    dcache_wr_wstrb = 0; dcache_wr_data = '0;
    test_reset();
    test_icache_line();
    test_arbitration();
    test_write_line();
    test_hazard();
    test_single_write(2'b00);
    test_bus_err_and_reset();
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_burst_bridge.md
Name: axi_burst_bridge

Overview:
- Parametrised cache-to-AXI3 bridge sitting between the icache/dcache miss and writeback ports and the SoC AXI master port.
- Arbitrates icache and dcache refills onto a single AR/R channel pair, with dcache given priority.
- Drives full-line write bursts, with correct per-beat wlast, from a dcache line buffer.
- Blocks reads that hit a line still being written back (read-after-write hazard); one outstanding read and one outstanding write at a time.

Parameters:
- DATA_W, 32, AXI data beat width in bits (32 or 64).
- LINE_WORDS, 4, beats per cache line; power of two, 2..16.
- ID_W, 4, AXI id width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- arid/araddr/arlen/arsize/arburst  out  ID_W/32/8/3/2  read address.
- arlock/arcache/arprot  out  2/4/3  constant 0.
- arvalid  out  1; arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1; rready  out  1.
- awid/awaddr/awlen/awsize/awburst  out  ID_W/32/8/3/2  write address.
- awlock/awcache/awprot  out  2/4/3  constant 0.
- awvalid  out  1; awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/DATA_W/8/1/1; wready  in  1.
- bid/bresp/bvalid  in  ID_W/2/1; bready  out  1.
- icache_rd_req/icache_rd_type/icache_rd_addr  in  1/3/32  refill request; type 3'b100 means line, otherwise single beat with size type[1:0].
- icache_rd_rdy  out  1  request accepted this cycle.
- icache_ret_valid/icache_ret_last/icache_ret_data  out  1/1/DATA_W.
- dcache_rd_req/dcache_rd_type/dcache_rd_addr  in  1/3/32.
- dcache_rd_rdy/dcache_ret_valid/dcache_ret_last/dcache_ret_data  out  1/1/1/DATA_W.
- dcache_wr_req/dcache_wr_type/dcache_wr_addr/dcache_wr_wstrb  in  1/3/32/DATA_W/8.
- dcache_wr_data  in  LINE_WORDS*DATA_W  line data; word 0 in the LSBs.
- dcache_wr_rdy  out  1  write accepted this cycle.
- bus_err  out  1  sticky AXI error flag.

Behaviour:
- Reset is asynchronous on negedge aresetn. While reset is low:
  - all FSMs return to IDLE;
  - arvalid, awvalid, wvalid, rready, bready, both ret_valid, both ret_last and bus_err are 0;
  - the address, len, data and beat-counter registers are 0.
- Reset asserted mid-transaction abandons the transaction with no drain.
- Constant outputs: arburst = awburst = 2'b01 (INCR); arid = {0, client}, where client is 0 for icache and 1 for dcache; awid = wid = 1.
- For line requests: len = LINE_WORDS-1 and size = log2(DATA_W/8). For single-beat requests: len = 0 and size = type[1:0].
- Read FSM states are R_IDLE, R_AR, R_DATA.
  - In R_IDLE, the dcache request wins over the icache request.
  - X_rd_rdy = 1 only for the granted requester, and only when there is no hazard. A request is accepted on X_rd_req & X_rd_rdy; id, addr, len and size are latched, then the FSM moves to R_AR.
  - R_AR: arvalid = 1 and the AR signals are held stable until arready; then R_DATA.
  - R_DATA: rready = 1. Each beat is forwarded the same cycle to the latched client: ret_valid = rvalid, ret_data = rdata, ret_last = rlast. On rvalid & rlast the FSM returns to R_IDLE.
  - Latency from acceptance to arvalid is 1 cycle.
- Hazard: a read is blocked (rd_rdy = 0) when its line address addr[31:log2(LINE_WORDS*DATA_W/8)] equals the line address of the write either pending (write FSM not idle) or being accepted in the same cycle. The block clears in the cycle after the b handshake.
- Write FSM states are W_IDLE, W_XFER, W_RESP.
  - dcache_wr_rdy = 1 exactly in W_IDLE. On acceptance, addr, data, wstrb and len are latched and the FSM enters W_XFER.
  - W_XFER: awvalid is asserted until the aw handshake and wvalid is asserted until the last w handshake; the two are independent and either may complete first.
  - Beat counter cnt increments on each w handshake. wdata = line word[cnt]; wlast = (cnt == len).
  - wstrb is all-ones for line writes and the latched dcache_wr_wstrb for single writes.
  - When both aw and the last w are done, the FSM enters W_RESP with bready = 1; bvalid returns it to W_IDLE.
- Read and write FSMs run concurrently; no ordering is enforced except the hazard rule.
- bus_err is set on an r or b handshake with resp != 0 and is cleared only by reset. Data is still forwarded normally.

Test Plan:
- Reset, then icache line read at 0x1C000000 with rready path: arlen = 3, arsize = 2, arid = 0. Four rdata beats 0xA0..0xA3 appear on icache_ret_data the same cycles; icache_ret_last is set on beat 3 only.
- icache_rd_req and dcache_rd_req asserted in the same cycle: dcache_rd_rdy = 1, icache_rd_rdy = 0, arid = 1. icache is granted after the dcache rlast.
- dcache line write at 0x80 with awready delayed 5 cycles and wready always 1: all 4 beats complete first, with wlast on beat 3 only. awvalid stays high until awready; bready is asserted only after both complete.
- Write to 0x100 pending, then dcache read at 0x108: dcache_rd_rdy = 0 until the cycle after bvalid. A read at 0x200 in parallel is accepted immediately.
- Single-beat write with type 3'b010, wstrb 4'b0011: awlen = 0, wstrb = 0011, wlast = 1 on the first beat.
- bresp = 2'b10: bus_err rises and stays 1. aresetn pulsed low mid R_DATA: rready, arvalid and bus_err drop to 0 immediately.
